// File: rtl/systolic_skew_buffer_pkg.sv
// Shared constants and the per-row delay rule for the systolic skew/deskew buffer.
package systolic_skew_buffer_pkg;

   localparam logic MODE_SKEW   = 1'b0;
   localparam logic MODE_DESKEW = 1'b1;

   // Cycles from an input element being sampled to its appearance at the output.
   // Skew staggers rows so row 0 leads; deskew undoes that so all rows realign.
   function automatic int delay_of(input int   row,
                                   input logic mode,
                                   input int   num_row,
                                   input int   extra_delay);
      if (mode == MODE_DESKEW) begin
         return num_row - row + extra_delay;
      end
      return row + 1 + extra_delay;
   endfunction

endpackage

// File: rtl/systolic_skew_buffer_row_delay.sv
// One row's shift chain: enable/clear controlled, tapped at a runtime index,
// with the output data gated by its travelling valid bit.
module skew_row_delay #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TAP_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic [TAP_W-1:0]      tap_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  any_valid_o
);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]                 valid_q, valid_d;

   // Next-state of the chain: clear wins, otherwise shift when enabled, else hold.
   // Empty slots carry all-zero data so dummies never leak stale values.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr_i) begin
         data_d  = '0;
         valid_d = '0;
      end else if (en_i) begin
         valid_d[0] = valid_i;
         data_d[0]  = valid_i ? data_i : '0;
         for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Output comes straight from a stage register selected by the tap.
   assign valid_o     = valid_q[tap_i];
   assign data_o      = valid_q[tap_i] ? data_q[tap_i] : '0;
   assign any_valid_o = |valid_q;

endmodule

// File: rtl/systolic_skew_buffer.sv
// Per-row delay buffer at a systolic array edge: skew mode staggers rows in,
// deskew mode realigns them out. Mode changes only when the buffer is empty.
module systolic_skew_buffer
   import systolic_skew_buffer_pkg::*;
#(
   parameter int NUM_ROW     = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int EXTRA_DELAY = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_mode,
   input  logic                          i_stall,
   input  logic                          i_flush,
   input  logic [NUM_ROW*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_ROW-1:0]            i_valid,
   output logic [NUM_ROW*DATA_WIDTH-1:0] o_data,
   output logic [NUM_ROW-1:0]            o_valid,
   output logic                          o_mode,
   output logic                          o_busy
);

   localparam int DEPTH = NUM_ROW + EXTRA_DELAY;
   localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic               mode_q, mode_d;
   logic               shift_en;
   logic [NUM_ROW-1:0] row_busy;

   // Flush beats stall; either one stops new elements entering.
   assign shift_en = !i_stall && !i_flush;

   // Accept a new mode only with nothing in flight and nothing arriving,
   // so no element can observe two different delays.
   always_comb begin
      mode_d = mode_q;
      if (!o_busy && (i_valid == '0) && !i_stall) begin
         mode_d = i_mode;
      end
   end

   // Applied-mode register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_SKEW;
      end else begin
         mode_q <= mode_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ROW; gi++) begin : g_row
         localparam int TAP_SKEW   = delay_of(gi, MODE_SKEW,   NUM_ROW, EXTRA_DELAY) - 1;
         localparam int TAP_DESKEW = delay_of(gi, MODE_DESKEW, NUM_ROW, EXTRA_DELAY) - 1;

         logic [TAP_W-1:0] tap;

         assign tap = (mode_q == MODE_DESKEW) ? TAP_W'(TAP_DESKEW) : TAP_W'(TAP_SKEW);

         skew_row_delay #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .TAP_W      (TAP_W)
         ) u_row (
            .clk         (clk),
            .rst         (rst),
            .en_i        (shift_en),
            .clr_i       (i_flush),
            .tap_i       (tap),
            .data_i      (i_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .valid_i     (i_valid[gi]),
            .data_o      (o_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o     (o_valid[gi]),
            .any_valid_o (row_busy[gi])
         );
      end
   endgenerate

   assign o_busy = |row_busy;
   assign o_mode = mode_q;

endmodule
